// File: rtl/sha256_compression_core.sv
// Iterative SHA-256 compression: one round per clock over 64 rounds, then the
// per-word feed-forward addition into the chaining value.
module sha256_compression_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    big_sigma0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    big_sigma1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    ch = (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    maj = (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_t       state, state_next;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] hsave;
  logic [255:0] working;
  logic [5:0]   t;
  logic         fire;
  logic         accept;
  logic [31:0]  t1, t2;

  assign working = {a, b, c, d, e, f, g, h};
  assign fire    = w_valid & w_ready;
  assign accept  = (state == IDLE) & start;

  // Round datapath: all sums wrap modulo 2^32 by truncation to 32 bits.
  always_comb begin
    t1 = h + big_sigma1(e) + ch(e, f, g) + K_ROM[t] + w_data;
    t2 = big_sigma0(a) + maj(a, b, c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    w_ready    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ROUND;
      end
      ROUND: begin
        w_ready = 1'b1;
        if (w_valid && (t == 6'd63)) state_next = FINAL;
      end
      FINAL: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      b     <= '0;
      c     <= '0;
      d     <= '0;
      e     <= '0;
      f     <= '0;
      g     <= '0;
      h     <= '0;
      hsave <= '0;
      t     <= '0;
    end else if (accept) begin
      hsave                    <= hash_in;
      {a, b, c, d, e, f, g, h} <= hash_in;
      t                        <= '0;
    end else if (fire) begin
      h <= g;
      g <= f;
      f <= e;
      e <= d + t1;
      d <= c;
      c <= b;
      b <= a;
      a <= t1 + t2;
      t <= t + 6'd1;
    end
  end

  // Feed-forward: eight independent 32-bit adds, no carry between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_out <= '0;
    end else if (state == FINAL) begin
      for (int i = 0; i < 8; i++) begin
        hash_out[i*32 +: 32] <= hsave[i*32 +: 32] + working[i*32 +: 32];
      end
    end
  end

endmodule

// File: doc/sha256_compression_core.md
# sha256_compression_core

Iterative SHA-256 compression engine that performs one round per clock over 64 rounds, then the final feed-forward addition. It sits downstream of the message scheduler, which supplies W_t words over a valid/ready handshake. It instantiates the Σ₀/Σ₁/Ch/Maj round functions internally and holds the 64-entry K constant ROM. Its 256-bit result goes to the top-level hash register / output interface.

## Interface
- No parameters. Round count (64) and K constants are fixed by FIPS 180-4.
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  begin a block; sampled only in IDLE
- hash_in  input  256  chaining value H0..H7, H0 in bits [255:224]; sampled on accepted start
- w_valid  input  1  W_t word available from scheduler
- w_data  input  32  W_t for the current round
- w_ready  output  1  core consumes w_data this cycle if w_valid=1
- busy  output  1  high from accepted start until done pulse ends
- done  output  1  one-cycle pulse: hash_out valid
- hash_out  output  256  H0'..H7', H0' in [255:224]; held until next done

## Operation
- States: IDLE, ROUND, FINAL, DONE.
- IDLE: start=1 → latch hash_in into H-save regs and into working a..h; round counter t=0; go ROUND.
- ROUND: w_ready=1. On w_valid&w_ready:
  - T1 = h + Σ₁(e) + Ch(e,f,g) + K[t] + w_data; T2 = Σ₀(a) + Maj(a,b,c).
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2; t←t+1.
  - If t==63 when the round fires → FINAL.
  - w_valid=0: registers and t hold (stall, no limit).
- FINAL: hash_out[i] ← H-save[i] + working[i] for each 32-bit word. Go to DONE. w_ready=0.
- DONE: done=1 for this one cycle; go IDLE.
- Arithmetic: every addition is modulo 2^32. Carries are discarded per word, with no inter-word carry.
- Σ₀(x)=ROTR2^ROTR13^ROTR22, Σ₁(x)=ROTR6^ROTR11^ROTR25, Ch=(e&f)^(~e&g), Maj=(a&b)^(a&c)^(b&c).
- t is a 6-bit counter. It never wraps inside a block, because the transition to FINAL occurs at t==63.
- start in ROUND/FINAL/DONE is ignored; no queuing.
- start and done in the same cycle: start is ignored (state is DONE, not IDLE).

## Timing
- Reset values: state=IDLE, w_ready=0, busy=0, done=0, hash_out=0, a..h=0, H-save=0, t=0.
- Reset mid-operation: immediate return to reset values. The partial block is discarded; no done.
- With w_valid held high, start accepted at edge E0:
  - Rounds fire on E1..E64.
  - FINAL is active after E64; hash_out is written at E65.
  - done is high in the cycle after E65.
  - Total start-to-done is 66 edges.
- Each cycle with w_valid=0 in ROUND adds exactly one cycle of latency.
- w_ready is combinational from state only (high iff ROUND), with no dependence on w_valid.
- busy = (state != IDLE); it drops in the cycle after done.
- The earliest next start is the cycle after done (IDLE).
- hash_out is stable from E65 until the next FINAL.

## Test plan
- "abc" single block:
  - Stimulus: hash_in = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; W0=61626380, W1..W14=0, W15=00000018, W16..63 from reference model; w_valid constant 1.
  - Required: done exactly 66 edges after start; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Stalls:
  - Stimulus: same block with w_valid randomly deasserted (≈30%).
  - Required: identical hash_out; latency = 66 + number of stall cycles in ROUND; a..h unchanged on stall cycles.
- Two-block chaining:
  - Stimulus: 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second block started with hash_in = first hash_out.
  - Required: final hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Start while busy:
  - Stimulus: pulse start with a different hash_in at round 10 and in the DONE cycle.
  - Required: both ignored; result unchanged; busy profile unchanged.
- Reset mid-run:
  - Stimulus: assert rst_n=0 asynchronously at round 30.
  - Required: all outputs 0 without waiting for a clock edge; no done; the next block after release produces the correct "abc" digest.
- Reset state:
  - Stimulus: hold reset, then release with no start.
  - Required: w_ready=0, busy=0, done=0, hash_out=0 indefinitely.
